// File: rtl/btn_led_toggle_bank_if.sv
// Button/LED bundle between the board-side driver and the toggle bank.
// The master side drives the raw buttons and the clear; the slave side returns the LEDs and the strobes.
interface btn_led_toggle_bank_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] btn;
  logic            led_clr;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] press_pulse;
  logic            long_pulse;

  modport master (
    output btn, led_clr,
    input  led, press_pulse, long_pulse
  );

  modport slave (
    input  btn, led_clr,
    output led, press_pulse, long_pulse
  );
endinterface

// File: rtl/btn_led_toggle_bank.sv
// Bank of debounced push-button to LED toggle channels with one-cycle press strobes.
// Optional feature: define BTN_LONGPRESS_EN to add the long-press clear of all LEDs.
module btn_led_toggle_bank #(
  parameter int   N_CH            = 2,
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic BTN_IDLE        = 1'b1,
  parameter int   LONG_CYCLES     = 25000000
) (
  input logic                  clk,
  input logic                  rst,
  btn_led_toggle_bank_if.slave bus
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      settle;
  logic            settled;
  logic [N_CH-1:0] press_now;
  logic [N_CH-1:0] long_now;
  logic            led_kill;

  // The synchronisers hold reset values for two edges; a channel may only arm
  // once s2 carries a real button sample, so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= 2'd0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end
  end

  assign settled = (settle == 2'd2);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             stable;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1     <= BTN_IDLE;
        s2     <= BTN_IDLE;
        stable <= BTN_IDLE;
        cnt    <= '0;
        armed  <= 1'b0;
      end else begin
        s1 <= bus.btn[i];
        s2 <= s1;
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (settled && (s2 == BTN_IDLE)) begin
          armed <= 1'b1;
        end
      end
    end

    assign press_now[i] = armed && (s2 != stable) && (cnt == CNT_LAST) && (s2 != BTN_IDLE);

`ifdef BTN_LONGPRESS_EN
    localparam int              HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold;

    // Saturating one past the trigger value keeps long_pulse to once per held press.
    always_ff @(posedge clk) begin
      if (rst || (stable == BTN_IDLE)) begin
        hold <= '0;
      end else if (hold == HOLD_HIT) begin
        hold <= HOLD_SAT;
      end else if (hold != HOLD_SAT) begin
        hold <= hold + 1'b1;
      end
    end

    assign long_now[i] = (stable != BTN_IDLE) && (hold == HOLD_HIT);
`else
    assign long_now[i] = 1'b0;
`endif
  end

  assign led_kill = |long_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.led         <= '0;
      bus.press_pulse <= '0;
      bus.long_pulse  <= 1'b0;
    end else begin
      bus.press_pulse <= press_now;
      bus.long_pulse  <= led_kill;
      if (led_kill || bus.led_clr) begin
        bus.led <= '0;
      end else begin
        bus.led <= bus.led ^ press_now;
      end
    end
  end
endmodule
